// File: rtl/instr_fetcher_pkg.sv
`default_nettype none
// ============================================================================
// Module : instr_fetcher_pkg
// Purpose: Shared definitions for the instruction-fetch stage: RV32I opcode
//          constants, fetch FSM state encoding, reset PC default and the
//          static next-PC predictor.
// Ports  : none (package)
// Rev    : 1.0  initial release
// ============================================================================
package instr_fetcher_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // RV32I major opcodes (instr[6:0])
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    MISS = 1'b1
  } fetch_state_t;

  // Static predictor: JAL is always taken (its target is fully known from the
  // word itself); everything else, including branches and JALR, falls through.
  function automatic logic [31:0] pred_next_pc(input logic [31:0] pc,
                                               input logic [31:0] word);
    logic [31:0] imm_j;
    imm_j = {{11{word[31]}}, word[31], word[19:12], word[20], word[30:21], 1'b0};
    if (word[6:0] == OPC_JAL) begin
      return pc + imm_j;
    end
    return pc + 32'd4;
  endfunction

endpackage
`default_nettype wire

// File: rtl/instr_fetcher_icache.sv
`default_nettype none
// ============================================================================
// Module : icache_dm
// Purpose: Direct-mapped instruction cache, one 32-bit word per line.
//          Combinational lookup port, synchronous fill port.
// Ports  : clk, rst          - clock, synchronous active-high reset
//          lookup_word [29:0] - word address (pc[31:2]) to look up
//          hit, data          - lookup result
//          fill_en            - write a line this cycle
//          fill_word [29:0]   - word address of the line being filled
//          fill_data [31:0]   - instruction word to store
// Rev    : 1.0  initial release
// ============================================================================
module icache_dm #(
  parameter int IDX_W = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [29:0] lookup_word,
  output logic        hit,
  output logic [31:0] data,
  input  logic        fill_en,
  input  logic [29:0] fill_word,
  input  logic [31:0] fill_data
);

  localparam int LINES = 1 << IDX_W;
  localparam int TAG_W = 30 - IDX_W;

  logic [LINES-1:0] valid;
  logic [TAG_W-1:0] tags  [LINES];
  logic [31:0]      words [LINES];

  logic [IDX_W-1:0] lookup_idx;
  logic [TAG_W-1:0] lookup_tag;
  logic [IDX_W-1:0] fill_idx;
  logic [TAG_W-1:0] fill_tag;

  assign lookup_idx = lookup_word[IDX_W-1:0];
  assign lookup_tag = lookup_word[29:IDX_W];
  assign fill_idx   = fill_word[IDX_W-1:0];
  assign fill_tag   = fill_word[29:IDX_W];

  assign hit  = valid[lookup_idx] && (tags[lookup_idx] == lookup_tag);
  assign data = words[lookup_idx];

  // Only the valid bits need a reset; tag/data are qualified by them.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
    end else if (fill_en) begin
      valid[fill_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_en) begin
      tags[fill_idx]  <= fill_tag;
      words[fill_idx] <= fill_data;
    end
  end

endmodule
`default_nettype wire

// File: rtl/instr_fetcher.sv
`default_nettype none
// ============================================================================
// Module : instr_fetcher
// Purpose: Instruction-fetch stage. Holds the PC, looks it up in a small
//          direct-mapped icache, requests a word from the memory controller on
//          a miss, and hands instructions to the decoder with a static
//          next-PC prediction (JAL taken, else PC+4). Redirects on rob_clear.
// Ports  : clk, rst                   - clock, synchronous active-high reset
//          rdy                        - global enable, 0 freezes all state
//          rob_clear, rob_new_pc      - flush and redirect target
//          mem_req, mem_addr          - word request to memory controller
//          mem_ready, mem_instr,
//          mem_instr_addr             - returned word (one-cycle pulse)
//          dec_stall                  - decoder cannot accept this cycle
//          dec_valid, dec_instr,
//          dec_pc, dec_pred_pc        - instruction to decoder
// Rev    : 1.0  initial release
// ============================================================================
module instr_fetcher
  import instr_fetcher_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          IDX_W    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        rob_clear,
  input  logic [31:0] rob_new_pc,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic [31:0] mem_instr,
  input  logic [31:0] mem_instr_addr,
  input  logic        dec_stall,
  output logic        dec_valid,
  output logic [31:0] dec_instr,
  output logic [31:0] dec_pc,
  output logic [31:0] dec_pred_pc
);

  fetch_state_t state, state_n;
  logic [31:0]  pc, pc_n;
  logic         mem_req_n;
  logic [31:0]  mem_addr_n;
  logic         dec_valid_n;
  logic [31:0]  dec_instr_n;
  logic [31:0]  dec_pc_n;
  logic [31:0]  dec_pred_pc_n;
  logic [31:0]  pred;

  logic         hit;
  logic [31:0]  hit_word;
  logic         fill_req;
  logic         fill_en;

  // A fill is suppressed while frozen or flushing: a word returned in the
  // same cycle as rob_clear belongs to an abandoned request.
  assign fill_en = fill_req && rdy && !rob_clear;

  icache_dm #(
    .IDX_W (IDX_W)
  ) u_icache (
    .clk         (clk),
    .rst         (rst),
    .lookup_word (pc[31:2]),
    .hit         (hit),
    .data        (hit_word),
    .fill_en     (fill_en),
    .fill_word   (pc[31:2]),
    .fill_data   (mem_instr)
  );

  assign pred = pred_next_pc(pc, hit_word);

  always_comb begin
    state_n       = state;
    pc_n          = pc;
    mem_req_n     = mem_req;
    mem_addr_n    = mem_addr;
    dec_valid_n   = 1'b0;   // single-cycle pulse
    dec_instr_n   = dec_instr;
    dec_pc_n      = dec_pc;
    dec_pred_pc_n = dec_pred_pc;
    fill_req      = 1'b0;

    case (state)
      IDLE: begin
        if (hit) begin
          if (!dec_stall) begin
            dec_valid_n   = 1'b1;
            dec_instr_n   = hit_word;
            dec_pc_n      = pc;
            dec_pred_pc_n = pred;
            pc_n          = pred;
          end
        end else begin
          state_n    = MISS;
          mem_req_n  = 1'b1;
          mem_addr_n = pc;
        end
      end
      MISS: begin
        // Returns for any other address are stale and simply ignored.
        if (mem_ready && (mem_instr_addr == pc)) begin
          fill_req   = 1'b1;
          state_n    = IDLE;
          mem_req_n  = 1'b0;
          mem_addr_n = 32'h0;
        end
      end
      default: begin
        state_n    = IDLE;
        mem_req_n  = 1'b0;
        mem_addr_n = 32'h0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      mem_req     <= 1'b0;
      mem_addr    <= 32'h0;
      dec_valid   <= 1'b0;
      dec_instr   <= 32'h0;
      dec_pc      <= 32'h0;
      dec_pred_pc <= 32'h0;
    end else if (rob_clear) begin
      state     <= IDLE;
      pc        <= rob_new_pc;
      mem_req   <= 1'b0;
      mem_addr  <= 32'h0;
      dec_valid <= 1'b0;
    end else if (rdy) begin
      state       <= state_n;
      pc          <= pc_n;
      mem_req     <= mem_req_n;
      mem_addr    <= mem_addr_n;
      dec_valid   <= dec_valid_n;
      dec_instr   <= dec_instr_n;
      dec_pc      <= dec_pc_n;
      dec_pred_pc <= dec_pred_pc_n;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetcher.sv
`default_nettype none
// ============================================================================
// Module : tb_instr_fetcher
// Purpose: Self-checking bench for instr_fetcher. A table of single-fetch
//          records (pc, word, expected predicted pc) plus hand-written
//          sequences for streaming, stall, freeze, flush and conflict cases.
// Rev    : 1.0  initial release
// ============================================================================
module tb_instr_fetcher;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        rob_clear;
  logic [31:0] rob_new_pc;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic [31:0] mem_instr;
  logic [31:0] mem_instr_addr;
  logic        dec_stall;
  logic        dec_valid;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
  logic [31:0] dec_pred_pc;

  always #5 clk = ~clk;

  instr_fetcher #(
    .RESET_PC (32'h0),
    .IDX_W    (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .rdy            (rdy),
    .rob_clear      (rob_clear),
    .rob_new_pc     (rob_new_pc),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_ready      (mem_ready),
    .mem_instr      (mem_instr),
    .mem_instr_addr (mem_instr_addr),
    .dec_stall      (dec_stall),
    .dec_valid      (dec_valid),
    .dec_instr      (dec_instr),
    .dec_pc         (dec_pc),
    .dec_pred_pc    (dec_pred_pc)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
    logic [31:0] exp_pred;
    logic        follow;   // also fetch the predicted target and check it
  } vec_t;

  vec_t vecs [8];

  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic redirect(input logic [31:0] target);
    rob_clear  = 1'b1;
    rob_new_pc = target;
    step();
    rob_clear  = 1'b0;
    rob_new_pc = 32'h0;
  endtask

  // Wait (bounded) for a request, check its address, return the word.
  task automatic serve_miss(input string name, input logic [31:0] addr,
                            input logic [31:0] word);
    int i;
    i = 0;
    while (!mem_req && i < 20) begin
      step();
      i++;
    end
    check({name, " mem_req"}, {31'd0, mem_req}, 32'd1);
    check({name, " mem_addr"}, mem_addr, addr);
    mem_ready      = 1'b1;
    mem_instr      = word;
    mem_instr_addr = addr;
    step();
    mem_ready      = 1'b0;
    mem_instr      = 32'h0;
    mem_instr_addr = 32'h0;
  endtask

  // Wait (bounded) for dec_valid and check the emitted instruction.
  task automatic expect_emit(input string name, input logic [31:0] pc,
                             input logic [31:0] word, input logic [31:0] pred);
    int i;
    i = 0;
    while (!dec_valid && i < 20) begin
      step();
      i++;
    end
    check({name, " dec_valid"}, {31'd0, dec_valid}, 32'd1);
    check({name, " dec_pc"}, dec_pc, pc);
    check({name, " dec_instr"}, dec_instr, word);
    check({name, " dec_pred_pc"}, dec_pred_pc, pred);
  endtask

  logic [31:0] stream_words [4];

  initial begin
    vecs[0] = '{pc: 32'h0000_0020, word: 32'h0100_006F, exp_pred: 32'h0000_0030, follow: 1'b1};
    vecs[1] = '{pc: 32'h0000_0080, word: 32'hFF9F_F06F, exp_pred: 32'h0000_0078, follow: 1'b1};
    vecs[2] = '{pc: 32'hFFFF_FFFC, word: 32'h0000_0013, exp_pred: 32'h0000_0000, follow: 1'b0};
    vecs[3] = '{pc: 32'hFFFF_FFF0, word: 32'h0100_006F, exp_pred: 32'h0000_0000, follow: 1'b0};
    vecs[4] = '{pc: 32'h0000_0200, word: 32'h0000_0063, exp_pred: 32'h0000_0204, follow: 1'b0};
    vecs[5] = '{pc: 32'h0000_0300, word: 32'h0010_006F, exp_pred: 32'h0000_0B00, follow: 1'b0};
    vecs[6] = '{pc: 32'h0000_0400, word: 32'h0000_106F, exp_pred: 32'h0000_1400, follow: 1'b0};
    vecs[7] = '{pc: 32'h0000_1000, word: 32'h0000_006F, exp_pred: 32'h0000_1000, follow: 1'b0};

    stream_words[0] = 32'h0000_0013;
    stream_words[1] = 32'h0010_0093;
    stream_words[2] = 32'h0020_0113;
    stream_words[3] = 32'h0030_0193;

    rst            = 1'b1;
    rdy            = 1'b1;
    rob_clear      = 1'b0;
    rob_new_pc     = 32'h0;
    mem_ready      = 1'b0;
    mem_instr      = 32'h0;
    mem_instr_addr = 32'h0;
    dec_stall      = 1'b0;

    // Reset state
    step(); step(); step();
    check("reset mem_req", {31'd0, mem_req}, 32'd0);
    check("reset mem_addr", mem_addr, 32'h0);
    check("reset dec_valid", {31'd0, dec_valid}, 32'd0);
    check("reset dec_instr", dec_instr, 32'h0);
    check("reset dec_pc", dec_pc, 32'h0);
    check("reset dec_pred_pc", dec_pred_pc, 32'h0);
    rst = 1'b0;

    // Cold start: miss at 0, fill, emit one cycle after the fill
    serve_miss("cold", 32'h0, stream_words[0]);
    check("cold fill-cycle dec_valid", {31'd0, dec_valid}, 32'd0);
    step();
    expect_emit("cold", 32'h0, stream_words[0], 32'h4);

    // Preload lines 0x4..0xC by walking forward
    for (int k = 1; k < 4; k++) begin
      serve_miss("preload", 32'(k * 4), stream_words[k]);
      expect_emit("preload", 32'(k * 4), stream_words[k], 32'(k * 4 + 4));
    end

    // Hit streaming: four back-to-back emissions, no memory traffic
    redirect(32'h0);
    for (int k = 0; k < 4; k++) begin
      step();
      check("stream dec_valid", {31'd0, dec_valid}, 32'd1);
      check("stream dec_pc", dec_pc, 32'(k * 4));
      check("stream dec_instr", dec_instr, stream_words[k]);
      check("stream mem_req", {31'd0, mem_req}, 32'd0);
    end

    // Stall for three cycles after the first emission
    redirect(32'h0);
    step();
    check("stall first dec_pc", dec_pc, 32'h0);
    dec_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check("stall dec_valid", {31'd0, dec_valid}, 32'd0);
      check("stall mem_req", {31'd0, mem_req}, 32'd0);
    end
    dec_stall = 1'b0;
    step();
    check("stall resume dec_valid", {31'd0, dec_valid}, 32'd1);
    check("stall resume dec_pc", dec_pc, 32'h4);
    step();
    check("stall next dec_valid", {31'd0, dec_valid}, 32'd1);
    check("stall next dec_pc", dec_pc, 32'h8);

    // Freeze: rdy=0 holds everything, emission resumes afterwards
    redirect(32'h0);
    rdy = 1'b0;
    for (int k = 0; k < 2; k++) begin
      step();
      check("freeze dec_valid", {31'd0, dec_valid}, 32'd0);
    end
    rdy = 1'b1;
    step();
    check("unfreeze dec_valid", {31'd0, dec_valid}, 32'd1);
    check("unfreeze dec_pc", dec_pc, 32'h0);

    // Table: single fetches with prediction checks
    for (int v = 0; v < 8; v++) begin
      redirect(vecs[v].pc);
      serve_miss($sformatf("vec%0d", v), vecs[v].pc, vecs[v].word);
      expect_emit($sformatf("vec%0d", v), vecs[v].pc, vecs[v].word, vecs[v].exp_pred);
      if (vecs[v].follow) begin
        serve_miss($sformatf("vec%0d target", v), vecs[v].exp_pred, 32'h0000_0013);
        expect_emit($sformatf("vec%0d target", v), vecs[v].exp_pred, 32'h0000_0013,
                    vecs[v].exp_pred + 32'd4);
      end
    end

    // Flush mid-miss, with a return in the flush cycle and a later stale one
    redirect(32'h40);
    serve_miss("flush pre", 32'h40, 32'h0);
    check("flush pre-fill dec_valid", {31'd0, dec_valid}, 32'd0);
    // serve_miss already returned a word for 0x40; restart so it is outstanding
    redirect(32'h0000_0500);
    serve_miss("flush 500", 32'h0000_0500, 32'h0050_0293);
    expect_emit("flush 500", 32'h0000_0500, 32'h0050_0293, 32'h0000_0504);
    redirect(32'h0000_0540);   // index 0 collides with 0x500 only by tag
    begin : flush_seq
      int i;
      i = 0;
      while (!mem_req && i < 20) begin
        step();
        i++;
      end
      check("flush miss mem_addr", mem_addr, 32'h0000_0540);
      rob_clear      = 1'b1;
      rob_new_pc     = 32'h100;
      mem_ready      = 1'b1;
      mem_instr      = 32'h0070_0393;
      mem_instr_addr = 32'h0000_0540;
      step();
      rob_clear      = 1'b0;
      rob_new_pc     = 32'h0;
      mem_ready      = 1'b0;
      check("flush mem_req drop", {31'd0, mem_req}, 32'd0);
      check("flush dec_valid", {31'd0, dec_valid}, 32'd0);
      i = 0;
      while (!mem_req && i < 20) begin
        step();
        i++;
      end
      check("restart mem_addr", mem_addr, 32'h100);
      mem_ready      = 1'b1;
      mem_instr_addr = 32'h0000_0540;
      step();
      mem_ready      = 1'b0;
      mem_instr      = 32'h0;
      mem_instr_addr = 32'h0;
      check("stale mem_req held", {31'd0, mem_req}, 32'd1);
      check("stale mem_addr held", mem_addr, 32'h100);
      check("stale dec_valid", {31'd0, dec_valid}, 32'd0);
    end
    serve_miss("restart", 32'h100, 32'h0000_0013);
    expect_emit("restart", 32'h100, 32'h0000_0013, 32'h104);

    // Dropped return must not have filled 0x540
    redirect(32'h0000_0540);
    serve_miss("no-fill 540", 32'h0000_0540, 32'h0080_0413);
    expect_emit("no-fill 540", 32'h0000_0540, 32'h0080_0413, 32'h0000_0544);

    // Conflict: 0x0 and 0x40 share index 0 and evict each other
    redirect(32'h0);
    serve_miss("conflict 0", 32'h0, 32'h00A0_0513);
    expect_emit("conflict 0", 32'h0, 32'h00A0_0513, 32'h4);
    redirect(32'h40);
    serve_miss("conflict 40", 32'h40, 32'h00B0_0593);
    expect_emit("conflict 40", 32'h40, 32'h00B0_0593, 32'h44);
    redirect(32'h0);
    serve_miss("refetch 0", 32'h0, 32'h00C0_0613);
    expect_emit("refetch 0", 32'h0, 32'h00C0_0613, 32'h4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
